flash_device_model: RTL and testbench
=====================================

Name: flash_device_model

Overview:
Synthesizable behavioural model of the parallel NOR flash on the NF_* pins. It is the device end of the bus that the flash controller drives.
- Decodes the controller's CE/OE/WE strobes into a small command set over an internal 256-byte array.
- Drives read data and the STS ready line back to the controller.
- Used in benches and as an on-chip loopback target, so the controller and manager can be brought up without the real chip.

Parameters:
READ_LAT, 3, cycles from CE&OE both sampled low (or address change) to valid data on NF_D_OUT
PROG_CYCLES, 10, busy duration of a byte program
ERASE_CYCLES, 100, busy duration of a block erase
INIT_VALUE, 8'hFF, array content after RST

Ports:
CLK_50MHZ  in  1  main clock
RST  in  1  synchronous active-high reset
NF_A  in  8  byte address
NF_D_IN  in  8  data/command from controller
NF_D_OUT  out  8  read data to controller
NF_D_OE  out  1  high while NF_D_OUT carries valid read data
NF_CE  in  1  chip enable, active low
NF_OE  in  1  output enable, active low
NF_WE  in  1  write enable, active low; bus cycle commits on its rising edge
NF_WP  in  1  write protect, active low (low = locked)
NF_RP  in  1  device reset, active low
NF_BYTE  in  1  ignored (byte mode only)
NF_STS  out  1  1 = ready, 0 = busy

Behaviour:
- One clock, synchronous active-high reset. All NF_* inputs are registered once before use.
- RST (all outputs and state):
  - array = INIT_VALUE
  - mode = READ_ARRAY, status = 8'h80
  - NF_D_OUT = 0, NF_D_OE = 0, NF_STS = 1
- Write cycle:
  - While registered CE=0 and WE=0, latch A and D_IN every cycle.
  - When WE goes 0->1 with CE=0, commit one bus write using the last latched A/D.
  - WE going high while CE=1 is ignored.
- Modes: READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE.
- Command decode in READ_ARRAY / READ_STATUS (address ignored):
  - FF -> READ_ARRAY
  - 70 -> READ_STATUS
  - 50 -> clear status bits 5, 4, 1; mode unchanged
  - 40 or 10 -> PROG_SETUP
  - 20 -> ERASE_SETUP
  - any other value -> ignored
- PROG_SETUP, next write (addr a, data d):
  - WP=1: BUSY_PROG for PROG_CYCLES. On completion array[a] = array[a] & d (bits only clear), then READ_STATUS.
  - WP=0: no change, set status bits 4 and 1, go to READ_STATUS.
- ERASE_SETUP, next write:
  - D0 with WP=1: BUSY_ERASE for ERASE_CYCLES. On completion the 16-byte block A[7:4] becomes 8'hFF, then READ_STATUS.
  - D0 with WP=0: set status bits 5 and 1, go to READ_STATUS.
  - any other value: command-sequence error; set bits 5 and 4, go to READ_STATUS.
- Busy handling:
  - NF_STS = 0 and status bit7 = 0 from the cycle after the committing write until the last busy cycle. Both return to 1 in the cycle the array update is applied.
  - Writes while busy are ignored.
  - Reads while busy return status.
- Read path:
  - Request = CE=0 and OE=0, registered.
  - A READ_LAT-deep pipeline carries {request, address}.
  - NF_D_OUT = array[A] in READ_ARRAY, otherwise the status register.
  - NF_D_OE goes high READ_LAT cycles after the request and falls READ_LAT cycles after CE or OE rises.
  - An address change mid-read updates the data READ_LAT cycles later.
  - When NF_D_OE = 0, NF_D_OUT = 0.
- WE and OE both low with CE low is illegal: write decode takes priority, the read request is suppressed.
- NF_RP = 0 (registered), for as long as it is held:
  - abort any busy operation; the array is unchanged because updates apply only at completion
  - mode = READ_ARRAY, status = 8'h80, NF_STS = 1, read pipeline cleared
  - all bus cycles ignored
- Status register bits: 7 ready, 5 erase/sequence error, 4 program/sequence error, 1 locked. All other bits read 0.

Test Plan:
- RST, then read A=8'h12 with CE=OE=0 -> NF_D_OE rises 3 cycles later, NF_D_OUT=8'hFF, NF_STS=1.
- Write 40 then (A=8'h05, D=8'h3C) -> NF_STS low exactly 10 cycles. Read at 8'h05 during busy returns 8'h00; after busy returns 8'h80. Write FF, read 8'h05 -> 8'h3C.
- Program 8'h05 again with D=8'hF0 -> array[8'h05]=8'h30. Erase 20/D0 at A=8'h0A -> STS low 100 cycles, then bytes 8'h00..8'h0F read 8'hFF and 8'h10 is unchanged.
- WP=0, then 40 then (A=8'h20, D=8'h00) -> no busy, status 8'h92, array unchanged. Command 50 -> status 8'h80.
- 20 then 8'hAA -> status 8'hB0, no erase. Command 50 -> 8'h80.
- Start an erase, pulse NF_RP low 2 cycles at busy cycle 40 -> STS high immediately, block unchanged, mode READ_ARRAY. Assert RST during a program -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/flash_device_model.sv
// Behavioural model of a small parallel NOR flash (256 bytes) on the NF_* bus.
// Decodes CE/OE/WE bus cycles into a command set; read data and STS are returned after a fixed latency.
module flash_device_model #(
    parameter int         READ_LAT     = 3,
    parameter int         PROG_CYCLES  = 10,
    parameter int         ERASE_CYCLES = 100,
    parameter logic [7:0] INIT_VALUE   = 8'hFF
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] NF_A,
    input  logic [7:0] NF_D_IN,
    output logic [7:0] NF_D_OUT,
    output logic       NF_D_OE,
    input  logic       NF_CE,
    input  logic       NF_OE,
    input  logic       NF_WE,
    input  logic       NF_WP,
    input  logic       NF_RP,
    input  logic       NF_BYTE,
    output logic       NF_STS
);
    // state       | meaning
    // READ_ARRAY  | reads return array contents
    // READ_STATUS | reads return the status register
    // PROG_SETUP  | next write supplies program address/data
    // ERASE_SETUP | next write must be the D0 confirm
    // BUSY_PROG   | program in progress, counting down
    // BUSY_ERASE  | block erase in progress, counting down
    typedef enum logic [2:0] {
        READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE
    } mode_t;

    localparam int MAXC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int LAST = READ_LAT - 2;

    mode_t         mode;
    logic [7:0]    a_r, d_r, lat_a, lat_d, op_a, op_d;
    logic          ce_r, oe_r, we_r, wp_r, rp_r, we_q;
    logic          err_e, err_p, locked;
    logic [CW-1:0] cnt;
    logic [7:0]    mem [256];
    logic [LAST:0] pipe_req;
    logic [7:0]    pipe_a [READ_LAT-1];
    logic          commit, rd_req;
    logic [7:0]    status;
    logic          unused_byte;

    assign unused_byte = NF_BYTE;
    assign status = {NF_STS, 1'b0, err_e, err_p, 2'b00, locked, 1'b0};
    assign commit = ~ce_r & we_r & ~we_q;
    // a simultaneous WE/OE strobe is treated as a write, never as a read
    assign rd_req = ~ce_r & ~oe_r & we_r;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            a_r <= '0; d_r <= '0; ce_r <= 1'b1; oe_r <= 1'b1; we_r <= 1'b1;
            wp_r <= 1'b1; rp_r <= 1'b1; we_q <= 1'b1;
            lat_a <= '0; lat_d <= '0; op_a <= '0; op_d <= '0;
            mode <= READ_ARRAY; err_e <= 1'b0; err_p <= 1'b0; locked <= 1'b0;
            cnt <= '0; NF_STS <= 1'b1; NF_D_OE <= 1'b0; NF_D_OUT <= '0;
            pipe_req <= '0;
            for (int i = 0; i < READ_LAT - 1; i++) pipe_a[i] <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= INIT_VALUE;
        end else begin
            a_r <= NF_A; d_r <= NF_D_IN; ce_r <= NF_CE; oe_r <= NF_OE;
            we_r <= NF_WE; wp_r <= NF_WP; rp_r <= NF_RP;
            if (!rp_r) begin
                // device reset abandons the operation before its array update
                mode <= READ_ARRAY; err_e <= 1'b0; err_p <= 1'b0; locked <= 1'b0;
                cnt <= '0; NF_STS <= 1'b1; NF_D_OE <= 1'b0; NF_D_OUT <= '0;
                pipe_req <= '0; we_q <= 1'b1;
            end else begin
                we_q <= we_r;
                if (!ce_r && !we_r) begin
                    lat_a <= a_r;
                    lat_d <= d_r;
                end
                pipe_req[0] <= rd_req;
                pipe_a[0]   <= a_r;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    pipe_req[i] <= pipe_req[i-1];
                    pipe_a[i]   <= pipe_a[i-1];
                end
                NF_D_OE <= pipe_req[LAST];
                if (pipe_req[LAST])
                    NF_D_OUT <= (mode == READ_ARRAY) ? mem[pipe_a[LAST]] : status;
                else
                    NF_D_OUT <= '0;

                case (mode)
                    READ_ARRAY, READ_STATUS: if (commit) begin
                        case (lat_d)
                            8'hFF: mode <= READ_ARRAY;
                            8'h70: mode <= READ_STATUS;
                            8'h50: begin err_e <= 1'b0; err_p <= 1'b0; locked <= 1'b0; end
                            8'h40, 8'h10: mode <= PROG_SETUP;
                            8'h20: mode <= ERASE_SETUP;
                            default: ;
                        endcase
                    end
                    PROG_SETUP: if (commit) begin
                        op_a <= lat_a;
                        op_d <= lat_d;
                        if (wp_r) begin
                            mode <= BUSY_PROG; NF_STS <= 1'b0; cnt <= CW'(PROG_CYCLES - 1);
                        end else begin
                            mode <= READ_STATUS; err_p <= 1'b1; locked <= 1'b1;
                        end
                    end
                    ERASE_SETUP: if (commit) begin
                        op_a <= lat_a;
                        mode <= READ_STATUS;
                        if (lat_d == 8'hD0 && wp_r) begin
                            mode <= BUSY_ERASE; NF_STS <= 1'b0; cnt <= CW'(ERASE_CYCLES - 1);
                        end else if (lat_d == 8'hD0) begin
                            err_e <= 1'b1; locked <= 1'b1;
                        end else begin
                            err_e <= 1'b1; err_p <= 1'b1;
                        end
                    end
                    BUSY_PROG: begin
                        if (cnt == '0) begin
                            mem[op_a] <= mem[op_a] & op_d;
                            NF_STS <= 1'b1; mode <= READ_STATUS;
                        end else cnt <= cnt - CW'(1);
                    end
                    BUSY_ERASE: begin
                        if (cnt == '0) begin
                            for (int i = 0; i < 16; i++) mem[{op_a[7:4], 4'(i)}] <= 8'hFF;
                            NF_STS <= 1'b1; mode <= READ_STATUS;
                        end else cnt <= cnt - CW'(1);
                    end
                    default: mode <= READ_ARRAY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flash_device_model.sv
// Directed bench for flash_device_model: bus reads/writes, program, erase, errors, NF_RP and RST.
module tb_flash_device_model;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] nf_a, nf_d_in, nf_d_out;
    logic       nf_d_oe, nf_ce, nf_oe, nf_we, nf_wp, nf_rp, nf_byte, nf_sts;
    int         n_vec = 0;
    int         n_err = 0;

    flash_device_model dut (
        .CLK_50MHZ(clk), .RST(rst), .NF_A(nf_a), .NF_D_IN(nf_d_in),
        .NF_D_OUT(nf_d_out), .NF_D_OE(nf_d_oe), .NF_CE(nf_ce), .NF_OE(nf_oe),
        .NF_WE(nf_we), .NF_WP(nf_wp), .NF_RP(nf_rp), .NF_BYTE(nf_byte), .NF_STS(nf_sts)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // returns one cycle after the committing edge
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        nf_a = a; nf_d_in = d; nf_ce = 1'b0; nf_we = 1'b0;
        tick(2);
        nf_we = 1'b1;
        tick(1);
        nf_ce = 1'b1;
        tick(1);
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        nf_a = a; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(4);
        chk({tag, "_oe"}, 8'(nf_d_oe), 8'h01);
        chk(tag, nf_d_out, exp);
        nf_ce = 1'b1; nf_oe = 1'b1;
        tick(4);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (nf_sts !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        chk({tag, "_ready"}, 8'(nf_sts), 8'h01);
    endtask

    initial begin
        rst = 1'b1; nf_a = '0; nf_d_in = '0; nf_ce = 1'b1; nf_oe = 1'b1; nf_we = 1'b1;
        nf_wp = 1'b1; nf_rp = 1'b1; nf_byte = 1'b0;
        tick(2);
        chk("rst_sts", 8'(nf_sts), 8'h01);
        chk("rst_doe", 8'(nf_d_oe), 8'h00);
        chk("rst_dout", nf_d_out, 8'h00);
        rst = 1'b0;
        tick(1);

        // read latency after reset
        nf_a = 8'h12; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(3);
        chk("lat_early_oe", 8'(nf_d_oe), 8'h00);
        tick(1);
        chk("lat_oe", 8'(nf_d_oe), 8'h01);
        chk("lat_data", nf_d_out, 8'hFF);
        chk("lat_sts", 8'(nf_sts), 8'h01);
        nf_ce = 1'b1; nf_oe = 1'b1;
        tick(3);
        chk("lat_hold_oe", 8'(nf_d_oe), 8'h01);
        tick(1);
        chk("lat_fall_oe", 8'(nf_d_oe), 8'h00);
        chk("lat_fall_dout", nf_d_out, 8'h00);

        // program 05 <- 3C, busy exactly 10 cycles, status read while busy
        bus_write(8'h00, 8'h40);
        chk("prog_setup_sts", 8'(nf_sts), 8'h01);
        bus_write(8'h05, 8'h3C);
        chk("prog_busy_start", 8'(nf_sts), 8'h00);
        nf_a = 8'h05; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(4);
        chk("busy_read_oe", 8'(nf_d_oe), 8'h01);
        chk("busy_read_data", nf_d_out, 8'h00);
        tick(5);
        chk("prog_busy_last", 8'(nf_sts), 8'h00);
        tick(1);
        chk("prog_busy_end", 8'(nf_sts), 8'h01);
        tick(1);
        chk("post_prog_status", nf_d_out, 8'h80);
        nf_ce = 1'b1; nf_oe = 1'b1;
        tick(4);
        bus_write(8'h00, 8'hFF);
        read_chk("prog_3c", 8'h05, 8'h3C);

        // address change mid-read follows after READ_LAT cycles
        nf_a = 8'h05; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(5);
        nf_a = 8'h06;
        tick(3);
        chk("addr_chg_old", nf_d_out, 8'h3C);
        tick(1);
        chk("addr_chg_new", nf_d_out, 8'hFF);
        nf_ce = 1'b1; nf_oe = 1'b1;
        tick(4);

        // reprogram clears bits only; put a marker in the next block
        bus_write(8'h00, 8'h10);
        bus_write(8'h05, 8'hF0);
        wait_ready("prog2");
        bus_write(8'h00, 8'h40);
        bus_write(8'h10, 8'h5A);
        wait_ready("prog3");
        bus_write(8'h00, 8'hFF);
        read_chk("prog_and", 8'h05, 8'h30);

        // block erase of 00..0F, busy exactly 100 cycles
        bus_write(8'h0A, 8'h20);
        bus_write(8'h0A, 8'hD0);
        chk("erase_busy_start", 8'(nf_sts), 8'h00);
        tick(99);
        chk("erase_busy_last", 8'(nf_sts), 8'h00);
        tick(1);
        chk("erase_busy_end", 8'(nf_sts), 8'h01);
        bus_write(8'h00, 8'hFF);
        read_chk("erase_00", 8'h00, 8'hFF);
        read_chk("erase_05", 8'h05, 8'hFF);
        read_chk("erase_0f", 8'h0F, 8'hFF);
        read_chk("erase_10_kept", 8'h10, 8'h5A);

        // write-protected program
        nf_wp = 1'b0;
        bus_write(8'h00, 8'h40);
        bus_write(8'h20, 8'h00);
        chk("wp_no_busy", 8'(nf_sts), 8'h01);
        read_chk("wp_status", 8'h20, 8'h92);
        bus_write(8'h00, 8'h50);
        read_chk("wp_clear", 8'h20, 8'h80);
        bus_write(8'h00, 8'hFF);
        read_chk("wp_unchanged", 8'h20, 8'hFF);
        nf_wp = 1'b1;

        // bad erase confirm
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'hAA);
        chk("seq_no_busy", 8'(nf_sts), 8'h01);
        read_chk("seq_status", 8'h00, 8'hB0);
        bus_write(8'h00, 8'h50);
        read_chk("seq_clear", 8'h00, 8'h80);

        // NF_RP pulse aborts an erase of block 3
        bus_write(8'h00, 8'hFF);
        bus_write(8'h00, 8'h40);
        bus_write(8'h30, 8'h66);
        wait_ready("prog4");
        bus_write(8'h30, 8'h20);
        bus_write(8'h30, 8'hD0);
        chk("rp_busy", 8'(nf_sts), 8'h00);
        tick(39);
        nf_rp = 1'b0;
        tick(2);
        nf_rp = 1'b1;
        chk("rp_sts_high", 8'(nf_sts), 8'h01);
        tick(3);
        chk("rp_sts_stays", 8'(nf_sts), 8'h01);
        read_chk("rp_block_kept", 8'h30, 8'h66);
        read_chk("rp_block_other", 8'h31, 8'hFF);

        // RST in the middle of a program with a read active
        bus_write(8'h00, 8'h40);
        bus_write(8'h40, 8'h11);
        nf_a = 8'h40; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(4);
        chk("rst_pre_oe", 8'(nf_d_oe), 8'h01);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_sts", 8'(nf_sts), 8'h01);
        chk("rst_mid_doe", 8'(nf_d_oe), 8'h00);
        chk("rst_mid_dout", nf_d_out, 8'h00);
        rst = 1'b0; nf_ce = 1'b1; nf_oe = 1'b1;
        tick(2);
        read_chk("rst_prog_lost", 8'h40, 8'hFF);
        read_chk("rst_array_init", 8'h30, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
